// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of alu_arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface alu_arbiter_if #(
   parameter int unsigned CNT_W = 16
) ();
   logic             req0_valid;
   logic             req0_ready;
   logic [31:0]      req0_A;
   logic [31:0]      req0_B;
   logic [3:0]       req0_sel;
   logic             req0_Cin;
   logic             req1_valid;
   logic             req1_ready;
   logic [31:0]      req1_A;
   logic [31:0]      req1_B;
   logic [3:0]       req1_sel;
   logic             req1_Cin;
   logic [31:0]      alu_A;
   logic [31:0]      alu_B;
   logic [3:0]       alu_sel;
   logic             alu_Cin;
   logic [31:0]      alu_Y;
   logic             alu_Cout;
   logic             alu_Negative;
   logic             alu_Zero;
   logic             alu_Overflow;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [31:0]      rsp_Y;
   logic [3:0]       rsp_flags;
   logic             rsp_err;
   logic             busy;
   logic [CNT_W-1:0] gnt_cnt0;
   logic [CNT_W-1:0] gnt_cnt1;

   modport slave (
      input  req0_valid, req0_A, req0_B, req0_sel, req0_Cin,
      input  req1_valid, req1_A, req1_B, req1_sel, req1_Cin,
      input  alu_Y, alu_Cout, alu_Negative, alu_Zero, alu_Overflow,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output alu_A, alu_B, alu_sel, alu_Cin,
      output rsp_valid, rsp_id, rsp_Y, rsp_flags, rsp_err,
      output busy, gnt_cnt0, gnt_cnt1
   );

   modport master (
      output req0_valid, req0_A, req0_B, req0_sel, req0_Cin,
      output req1_valid, req1_A, req1_B, req1_sel, req1_Cin,
      output alu_Y, alu_Cout, alu_Negative, alu_Zero, alu_Overflow,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_A, alu_B, alu_sel, alu_Cin,
      input  rsp_valid, rsp_id, rsp_Y, rsp_flags, rsp_err,
      input  busy, gnt_cnt0, gnt_cnt1
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// Operands are held on the ALU for ALU_LAT cycles, then the result returns tagged by id.
module alu_arbiter #(
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned CNT_W   = 16
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   localparam logic [1:0] ExecLoad = 2'(ALU_LAT - 1);

   state_e           state_q, state_d;
   logic             prio_q;
   logic [1:0]       exec_cnt_q;
   logic [31:0]      alu_a_q, alu_b_q;
   logic [3:0]       alu_sel_q;
   logic             alu_cin_q;
   logic             rsp_id_q, rsp_err_q;
   logic [31:0]      rsp_y_q;
   logic [3:0]       rsp_flags_q;
   logic [CNT_W-1:0] cnt0_q, cnt1_q;
   logic             gnt_any, gnt_id, hs;
   logic             rdy0, rdy1, busy, rsp_valid;
   logic [3:0]       sel_m;

   // A lone valid always wins; on a tie the side named by prio_q wins.
   assign gnt_any = bus.req0_valid | bus.req1_valid;
   assign gnt_id  = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;
   assign hs      = (state_q == StIdle) & gnt_any & ~rst;
   assign sel_m   = gnt_id ? bus.req1_sel : bus.req0_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (hs) state_d = StExec;
         StExec:  if (exec_cnt_q == 2'd0) state_d = StResp;
         StResp:  if (bus.rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rdy0      = 1'b0;
      rdy1      = 1'b0;
      busy      = (state_q != StIdle);
      rsp_valid = (state_q == StResp);
      if ((state_q == StIdle) && !rst && gnt_any) begin
         rdy0 = ~gnt_id;
         rdy1 = gnt_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q      <= 1'b0;
         exec_cnt_q  <= 2'd0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         alu_cin_q   <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_y_q     <= '0;
         rsp_flags_q <= '0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else if (hs) begin
         alu_a_q    <= gnt_id ? bus.req1_A : bus.req0_A;
         alu_b_q    <= gnt_id ? bus.req1_B : bus.req0_B;
         alu_sel_q  <= sel_m;
         alu_cin_q  <= gnt_id ? bus.req1_Cin : bus.req0_Cin;
         rsp_id_q   <= gnt_id;
         rsp_err_q  <= &sel_m[3:1];
         prio_q     <= ~gnt_id;
         exec_cnt_q <= ExecLoad;
         if (gnt_id) cnt1_q <= cnt1_q + CNT_W'(1);
         else        cnt0_q <= cnt0_q + CNT_W'(1);
      end else if (state_q == StExec) begin
         if (exec_cnt_q == 2'd0) begin
            rsp_y_q     <= bus.alu_Y;
            rsp_flags_q <= {bus.alu_Cout, bus.alu_Negative, bus.alu_Zero, bus.alu_Overflow};
         end else begin
            exec_cnt_q <= exec_cnt_q - 2'd1;
         end
      end
   end

   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.alu_A      = alu_a_q;
   assign bus.alu_B      = alu_b_q;
   assign bus.alu_sel    = alu_sel_q;
   assign bus.alu_Cin    = alu_cin_q;
   assign bus.rsp_valid  = rsp_valid;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_Y      = rsp_y_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.busy       = busy;
   assign bus.gnt_cnt0   = cnt0_q;
   assign bus.gnt_cnt1   = cnt1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT=1 and 3) each driving a behavioural ALU,
// checked against an arbitration/response model built from the block's rules.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   vec_n = 0;
   int   miss_n = 0;
   int   cyc = 0;
   int   hs_cyc = 0;

   // Reference model state for instance a
   int          fav_a = 0;
   int          cnt_a[2] = '{0, 0};
   logic [31:0] pa[2], pb[2];
   logic [3:0]  ps[2];
   logic        pc[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_arbiter_if #(.CNT_W(16)) ifa ();
   alu_arbiter_if #(.CNT_W(16)) ifb ();

   alu_arbiter #(.ALU_LAT(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
   alu_arbiter #(.ALU_LAT(3), .CNT_W(16)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

   // Result layout: {Cout, Negative, Zero, Overflow, Y}
   function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] sel, input logic cin);
      logic [32:0] s;
      logic [31:0] y;
      logic        c, v;
      c = 1'b0;
      v = 1'b0;
      y = a;
      case (sel)
         4'b0000: y = a & b;
         4'b0001: y = a | b;
         4'b0010: y = a ^ b;
         4'b0011: y = ~(a | b);
         4'b0100: y = a << b[4:0];
         4'b0101: y = a >> b[4:0];
         4'b0110: begin
            s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            y = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (y[31] != a[31]);
         end
         4'b0111: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            y = s[31:0];
            c = s[32];
            v = (a[31] != b[31]) && (y[31] != a[31]);
         end
         4'b1110, 4'b1111: return 36'd0;
         default: y = a;
      endcase
      return {c, y[31], (y == 32'd0), v, y};
   endfunction

   always_comb {ifa.alu_Cout, ifa.alu_Negative, ifa.alu_Zero, ifa.alu_Overflow, ifa.alu_Y} =
      alu_f(ifa.alu_A, ifa.alu_B, ifa.alu_sel, ifa.alu_Cin);
   always_comb {ifb.alu_Cout, ifb.alu_Negative, ifb.alu_Zero, ifb.alu_Overflow, ifb.alu_Y} =
      alu_f(ifb.alu_A, ifb.alu_B, ifb.alu_sel, ifb.alu_Cin);

   function automatic logic [142:0] outs_a();
      return {ifa.alu_A, ifa.alu_B, ifa.alu_sel, ifa.alu_Cin, ifa.rsp_valid, ifa.rsp_id,
              ifa.rsp_Y, ifa.rsp_flags, ifa.rsp_err, ifa.busy, ifa.gnt_cnt0, ifa.gnt_cnt1,
              ifa.req0_ready, ifa.req1_ready};
   endfunction

   function automatic logic [142:0] outs_b();
      return {ifb.alu_A, ifb.alu_B, ifb.alu_sel, ifb.alu_Cin, ifb.rsp_valid, ifb.rsp_id,
              ifb.rsp_Y, ifb.rsp_flags, ifb.rsp_err, ifb.busy, ifb.gnt_cnt0, ifb.gnt_cnt1,
              ifb.req0_ready, ifb.req1_ready};
   endfunction

   task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] s, input logic c);
      pa[id] = a;
      pb[id] = b;
      ps[id] = s;
      pc[id] = c;
      if (id == 0) begin
         ifa.req0_A = a; ifa.req0_B = b; ifa.req0_sel = s; ifa.req0_Cin = c;
      end else begin
         ifa.req1_A = a; ifa.req1_B = b; ifa.req1_sel = s; ifa.req1_Cin = c;
      end
   endtask

   // Raise valids, wait for a handshake, then for the response (consumed if rsp_ready is high).
   task automatic issue_a(input logic v0, input logic v1, output int hid, output int lat,
                          output logic [31:0] y, output logic [3:0] fl, output logic err,
                          output logic rid);
      hid = -1;
      lat = -1;
      y = '0;
      fl = '0;
      err = 1'b0;
      rid = 1'b0;
      ifa.req0_valid = v0;
      ifa.req1_valid = v1;
      for (int i = 0; i < 20 && hid < 0; i++) begin
         @(negedge clk);
         if (ifa.req0_valid && ifa.req0_ready) hid = 0;
         else if (ifa.req1_valid && ifa.req1_ready) hid = 1;
         if (hid >= 0) hs_cyc = cyc;
         @(posedge clk); #1;
      end
      ifa.req0_valid = 1'b0;
      ifa.req1_valid = 1'b0;
      if (hid < 0) return;
      for (int k = 1; k <= 10 && lat < 0; k++) begin
         @(negedge clk);
         if (ifa.rsp_valid) begin
            lat = k;
            y = ifa.rsp_Y;
            fl = ifa.rsp_flags;
            err = ifa.rsp_err;
            rid = ifa.rsp_id;
         end
      end
      if (lat >= 0 && ifa.rsp_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1; ifa.rsp_ready = 1'b0;
      ifb.req0_valid = 1'b1; ifb.req1_valid = 1'b1; ifb.rsp_ready = 1'b0;
      drive_req(0, '0, '0, '0, 1'b0);
      drive_req(1, '0, '0, '0, 1'b0);
      ifb.req0_A = '0; ifb.req0_B = '0; ifb.req0_sel = '0; ifb.req0_Cin = 1'b0;
      ifb.req1_A = '0; ifb.req1_B = '0; ifb.req1_sel = '0; ifb.req1_Cin = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vec_n++;
      if (outs_a() !== '0) begin
         miss_n++; $display("FAIL reset_a: outputs=%h required all zero", outs_a());
      end
      vec_n++;
      if (outs_b() !== '0) begin
         miss_n++; $display("FAIL reset_b: outputs=%h required all zero", outs_b());
      end
      ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
      ifb.req0_valid = 1'b0; ifb.req1_valid = 1'b0;
      @(posedge clk); #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      fav_a = 0;
      cnt_a = '{0, 0};
   endtask

   task automatic test_basic();
      int hid, lat;
      logic [31:0] y;
      logic [3:0]  fl;
      logic        err, rid;
      ifa.rsp_ready = 1'b1;
      drive_req(0, 32'd5, 32'd7, 4'b0110, 1'b0);
      issue_a(1'b1, 1'b0, hid, lat, y, fl, err, rid);
      fav_a = 1; cnt_a[0]++;
      vec_n++;
      if (hid != 0 || lat != 2 || rid !== 1'b0 || y !== 32'd12 || fl !== 4'b0000 || err !== 1'b0)
      begin
         miss_n++;
         $display("FAIL add_5_7: id=%0d lat=%0d rsp_id=%b Y=%h flags=%b err=%b required 0 2 0 0000000c 0000 0",
                  hid, lat, rid, y, fl, err);
      end
      vec_n++;
      if (ifa.gnt_cnt0 !== 16'd1 || ifa.gnt_cnt1 !== 16'd0) begin
         miss_n++;
         $display("FAIL cnt_after_first: cnt0=%0d cnt1=%0d required 1 0", ifa.gnt_cnt0, ifa.gnt_cnt1);
      end
      drive_req(1, 32'h7FFFFFFF, 32'd1, 4'b0110, 1'b0);
      issue_a(1'b0, 1'b1, hid, lat, y, fl, err, rid);
      fav_a = 0; cnt_a[1]++;
      vec_n++;
      if (hid != 1 || rid !== 1'b1 || y !== 32'h80000000 || fl !== 4'b0101 || err !== 1'b0) begin
         miss_n++;
         $display("FAIL add_overflow: id=%0d rsp_id=%b Y=%h flags=%b err=%b required 1 1 80000000 0101 0",
                  hid, rid, y, fl, err);
      end
   endtask

   task automatic test_round_robin();
      int hid, lat, eid, prev;
      logic [31:0] y;
      logic [3:0]  fl;
      logic        err, rid;
      int          c0, c1;
      c0 = cnt_a[0];
      c1 = cnt_a[1];
      prev = 0;
      ifa.rsp_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         drive_req(0, $urandom, $urandom, 4'b0110, 1'($urandom));
         drive_req(1, $urandom, $urandom, 4'b0111, 1'($urandom));
         eid = fav_a;
         issue_a(1'b1, 1'b1, hid, lat, y, fl, err, rid);
         fav_a = 1 - eid; cnt_a[eid]++;
         vec_n++;
         if (hid != (n % 2) || rid !== 1'(n % 2) || lat != 2) begin
            miss_n++;
            $display("FAIL rr_order[%0d]: id=%0d rsp_id=%b lat=%0d required %0d %0d 2",
                     n, hid, rid, lat, n % 2, n % 2);
         end
         if (n > 0) begin
            vec_n++;
            if (hs_cyc - prev != 3) begin
               miss_n++;
               $display("FAIL rr_interval[%0d]: %0d cycles required 3", n, hs_cyc - prev);
            end
         end
         prev = hs_cyc;
      end
      vec_n++;
      if (ifa.gnt_cnt0 !== 16'(c0 + 3) || ifa.gnt_cnt1 !== 16'(c1 + 3)) begin
         miss_n++;
         $display("FAIL rr_counts: cnt0=%0d cnt1=%0d required %0d %0d",
                  ifa.gnt_cnt0, ifa.gnt_cnt1, c0 + 3, c1 + 3);
      end
   endtask

   task automatic test_hold();
      int hid, lat;
      logic [31:0] y, ey;
      logic [3:0]  fl, ef;
      logic        err, rid;
      ifa.rsp_ready = 1'b0;
      drive_req(0, $urandom, $urandom, 4'b0010, 1'b0);
      {ef, ey} = alu_f(pa[0], pb[0], ps[0], pc[0]);
      issue_a(1'b1, 1'b0, hid, lat, y, fl, err, rid);
      fav_a = 1; cnt_a[0]++;
      vec_n++;
      if (hid != 0 || lat != 2 || y !== ey || fl !== ef) begin
         miss_n++;
         $display("FAIL hold_first: id=%0d lat=%0d Y=%h flags=%b required 0 2 %h %b",
                  hid, lat, y, fl, ey, ef);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         // Requests raised and withdrawn while the response is stalled
         ifa.req0_valid = (i == 1 || i == 2);
         ifa.req1_valid = (i == 1 || i == 2);
         @(negedge clk);
         vec_n++;
         if ({ifa.rsp_valid, ifa.busy, ifa.req0_ready, ifa.req1_ready} !== 4'b1100 ||
             ifa.rsp_Y !== ey || ifa.rsp_flags !== ef || ifa.rsp_id !== 1'b0 ||
             ifa.alu_A !== pa[0]) begin
            miss_n++;
            $display("FAIL hold_stall[%0d]: valid/busy/rdy0/rdy1=%b%b%b%b Y=%h flags=%b id=%b A=%h required 1100 %h %b 0 %h",
                     i, ifa.rsp_valid, ifa.busy, ifa.req0_ready, ifa.req1_ready, ifa.rsp_Y,
                     ifa.rsp_flags, ifa.rsp_id, ifa.alu_A, ey, ef, pa[0]);
         end
      end
      ifa.req0_valid = 1'b0;
      ifa.req1_valid = 1'b0;
      ifa.rsp_ready = 1'b1;
      @(negedge clk);
      vec_n++;
      if (ifa.busy !== 1'b0 || ifa.rsp_valid !== 1'b0) begin
         miss_n++;
         $display("FAIL hold_release: busy=%b rsp_valid=%b required 0 0", ifa.busy, ifa.rsp_valid);
      end
      @(posedge clk); #1;
      drive_req(0, $urandom, $urandom, 4'b0000, 1'b0);
      drive_req(1, $urandom, $urandom, 4'b0001, 1'b0);
      issue_a(1'b1, 1'b1, hid, lat, y, fl, err, rid);
      vec_n++;
      if (hid != fav_a) begin
         miss_n++;
         $display("FAIL hold_pointer: tie went to %0d required %0d", hid, fav_a);
      end
      cnt_a[fav_a]++; fav_a = 1 - fav_a;
   endtask

   task automatic test_random();
      int hid, lat, eid, v;
      logic [31:0] y;
      logic [3:0]  fl;
      logic        err, rid, v0, v1;
      logic [35:0] e;
      ifa.rsp_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         v = $urandom_range(1, 3);
         v0 = v[0];
         v1 = v[1];
         drive_req(0, $urandom, $urandom, 4'($urandom), 1'($urandom));
         drive_req(1, $urandom, $urandom, 4'($urandom), 1'($urandom));
         eid = (v0 && v1) ? fav_a : (v1 ? 1 : 0);
         e = alu_f(pa[eid], pb[eid], ps[eid], pc[eid]);
         issue_a(v0, v1, hid, lat, y, fl, err, rid);
         fav_a = 1 - eid; cnt_a[eid]++;
         vec_n++;
         if (hid != eid || lat != 2 || rid !== 1'(eid)) begin
            miss_n++;
            $display("FAIL rand_grant[%0d]: id=%0d rsp_id=%b lat=%0d required %0d %0d 2",
                     n, hid, rid, lat, eid, eid);
         end
         vec_n++;
         if ({fl, y} !== e || err !== (&ps[eid][3:1])) begin
            miss_n++;
            $display("FAIL rand_result[%0d]: flags=%b Y=%h err=%b required %b %h %b",
                     n, fl, y, err, e[35:32], e[31:0], &ps[eid][3:1]);
         end
         vec_n++;
         if (ifa.gnt_cnt0 !== 16'(cnt_a[0]) || ifa.gnt_cnt1 !== 16'(cnt_a[1])) begin
            miss_n++;
            $display("FAIL rand_counts[%0d]: cnt0=%0d cnt1=%0d required %0d %0d",
                     n, ifa.gnt_cnt0, ifa.gnt_cnt1, cnt_a[0], cnt_a[1]);
         end
      end
   endtask

   task automatic test_lat3();
      logic        hs;
      int          lat;
      logic [31:0] y;
      logic [3:0]  fl;
      logic        err, rid;
      logic [37:0] exp_v;
      ifb.rsp_ready = 1'b1;
      for (int j = 0; j < 2; j++) begin
         if (j == 0) begin
            ifb.req0_A = $urandom; ifb.req0_B = $urandom; ifb.req0_sel = 4'b1111;
            ifb.req0_Cin = 1'b1; ifb.req0_valid = 1'b1;
            exp_v = {1'b0, 32'd0, 4'b0000, 1'b1};
         end else begin
            ifb.req1_A = 32'd3; ifb.req1_B = 32'd4; ifb.req1_sel = 4'b0110;
            ifb.req1_Cin = 1'b0; ifb.req1_valid = 1'b1;
            exp_v = {1'b1, 32'd7, 4'b0000, 1'b0};
         end
         hs = 1'b0;
         for (int i = 0; i < 10 && !hs; i++) begin
            @(negedge clk);
            hs = (ifb.req0_valid && ifb.req0_ready) || (ifb.req1_valid && ifb.req1_ready);
            @(posedge clk); #1;
         end
         ifb.req0_valid = 1'b0;
         ifb.req1_valid = 1'b0;
         lat = -1;
         {rid, y, fl, err} = '0;
         for (int k = 1; k <= 10 && lat < 0 && hs; k++) begin
            @(negedge clk);
            if (ifb.rsp_valid) begin
               lat = k;
               {rid, y, fl, err} = {ifb.rsp_id, ifb.rsp_Y, ifb.rsp_flags, ifb.rsp_err};
            end
         end
         vec_n++;
         if (!hs || lat != 4 || {rid, y, fl, err} !== exp_v) begin
            miss_n++;
            $display("FAIL lat3[%0d]: hs=%b lat=%0d id/Y/flags/err=%h required 1 4 %h",
                     j, hs, lat, {rid, y, fl, err}, exp_v);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      int hid, lat;
      logic [31:0] y;
      logic [3:0]  fl;
      logic        err, rid, seen;
      logic [35:0] e;
      ifa.rsp_ready = 1'b1;
      drive_req(1, 32'h1234, 32'h10, 4'b0110, 1'b0);
      ifa.req1_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      ifa.req1_valid = 1'b0;
      vec_n++;
      if (ifa.busy !== 1'b1) begin
         miss_n++; $display("FAIL mid_exec_busy: busy=%b required 1", ifa.busy);
      end
      #2 rst_a = 1'b1;
      #1;
      vec_n++;
      if (outs_a() !== '0) begin
         miss_n++; $display("FAIL mid_reset_outputs: outputs=%h required all zero", outs_a());
      end
      ifa.req0_valid = 1'b1;
      ifa.req1_valid = 1'b1;
      @(negedge clk);
      vec_n++;
      if ({ifa.req0_ready, ifa.req1_ready, ifa.busy} !== 3'b000) begin
         miss_n++;
         $display("FAIL mid_reset_ready: rdy0/rdy1/busy=%b%b%b required 000",
                  ifa.req0_ready, ifa.req1_ready, ifa.busy);
      end
      ifa.req0_valid = 1'b0;
      ifa.req1_valid = 1'b0;
      @(posedge clk); #1;
      rst_a = 1'b0;
      fav_a = 0;
      cnt_a = '{0, 0};
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ifa.rsp_valid) seen = 1'b1;
      end
      vec_n++;
      if (seen !== 1'b0) begin
         miss_n++; $display("FAIL mid_reset_no_rsp: rsp_valid seen=%b required 0", seen);
      end
      @(posedge clk); #1;
      drive_req(0, $urandom, $urandom, 4'b0110, 1'b1);
      drive_req(1, $urandom, $urandom, 4'b0111, 1'b0);
      e = alu_f(pa[0], pb[0], ps[0], pc[0]);
      issue_a(1'b1, 1'b1, hid, lat, y, fl, err, rid);
      fav_a = 1; cnt_a[0]++;
      vec_n++;
      if (hid != 0 || rid !== 1'b0 || {fl, y} !== e || ifa.gnt_cnt0 !== 16'd1 ||
          ifa.gnt_cnt1 !== 16'd0) begin
         miss_n++;
         $display("FAIL post_reset_tie: id=%0d rsp_id=%b flags/Y=%h cnt0=%0d cnt1=%0d required 0 0 %h 1 0",
                  hid, rid, {fl, y}, ifa.gnt_cnt0, ifa.gnt_cnt1, e);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_hold();
      test_random();
      test_lat3();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
      $fatal(1, "watchdog expired");
   end
endmodule
